// File: rtl/msg_schedule_stream.sv
// ---------------------------------------------------------------------------
// msg_schedule_stream
//
// Sequential SHA-256 message-schedule generator. A 512-bit block arrives as
// 16 x 32-bit words (W[0] first) over a valid/ready input. The block then
// streams W[0..NUM_ROUNDS-1] in round order over a valid/ready output.
// A 16-entry circular window holds the most recent schedule words. Each
// expanded word W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
// overwrites the slot of W[t-16], which is the oldest word in the window.
//
// Parameters
//   NUM_ROUNDS  schedule words emitted per block, legal range 17..64
//
// Ports
//   clk        single clock, all state updates on the rising edge
//   rst_n      asynchronous, active-low reset
//   start      one-cycle request to begin a block, honoured only in IDLE
//   in_word    message word
//   in_valid   in_word is valid
//   in_ready   block accepts in_word (high throughout LOAD)
//   out_word   schedule word W[out_round], registered
//   out_round  round index of out_word, registered
//   out_valid  out_word/out_round are valid
//   out_ready  consumer accepts out_word
//   busy       high in LOAD or EMIT
//   done       one-cycle pulse after the last schedule word transfers
//
// Build option
//   MSG_SCHEDULE_BYTESWAP_EN  when defined, every accepted in_word is
//   byte-reversed before it is stored, for little-endian hosts. Ports and
//   timing are the same in both builds.
// ---------------------------------------------------------------------------
module msg_schedule_stream #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_round,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT
    } state_t;

    localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] out_word_q, out_word_d;
    logic [5:0]  out_round_q, out_round_d;
    logic        out_valid_q, out_valid_d;
    logic        done_q, done_d;

    logic [31:0] win_q [16];
    logic        win_we;
    logic [3:0]  win_addr;
    logic [31:0] win_wdata;

    logic        in_fire;
    logic        out_fire;
    logic [31:0] store_word;
    logic [5:0]  next_round;
    logic [3:0]  idx_m2;
    logic [3:0]  idx_m7;
    logic [3:0]  idx_m15;
    logic [3:0]  idx_m16;
    logic [31:0] w_new;

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign out_word  = out_word_q;
    assign out_round = out_round_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

`ifdef MSG_SCHEDULE_BYTESWAP_EN
    assign store_word = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
    assign store_word = in_word;
`endif

    // Window slots for the word being produced. When the current round is t,
    // the next word is W[t+1]; its taps W[t-1], W[t-6], W[t-14] and W[t-15]
    // live at those indices mod 16. Four-bit wrap-around does the modulo.
    // The W[t-15] slot is also where W[t+1] gets written.
    assign next_round = out_round_q + 6'd1;
    assign idx_m2     = out_round_q[3:0] - 4'd1;
    assign idx_m7     = out_round_q[3:0] - 4'd6;
    assign idx_m15    = out_round_q[3:0] - 4'd14;
    assign idx_m16    = out_round_q[3:0] + 4'd1;

    assign w_new = small_sigma1(win_q[idx_m2]) + win_q[idx_m7]
                 + small_sigma0(win_q[idx_m15]) + win_q[idx_m16];

    // Next-state and datapath control. LOAD fills the window one word per
    // accepted transfer; the 16th accept launches W[0] straight from the
    // window. In EMIT, each output handshake advances one round. The first
    // 16 rounds simply replay the window. Later rounds compute the new word
    // and store it over the slot it retires in the same edge. A stalled
    // consumer leaves everything untouched, because nothing moves without
    // out_fire.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_word_d  = out_word_q;
        out_round_d = out_round_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        win_we      = 1'b0;
        win_addr    = 4'd0;
        win_wdata   = 32'd0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = 4'd0;
                end
            end

            LOAD: begin
                if (in_fire) begin
                    win_we    = 1'b1;
                    win_addr  = cnt_q;
                    win_wdata = store_word;
                    cnt_d     = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d     = EMIT;
                        out_word_d  = win_q[0];
                        out_round_d = 6'd0;
                        out_valid_d = 1'b1;
                    end
                end
            end

            EMIT: begin
                if (out_fire) begin
                    if (out_round_q == LAST_ROUND) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        out_round_d = next_round;
                        if (next_round < 6'd16) begin
                            out_word_d = win_q[next_round[3:0]];
                        end else begin
                            out_word_d = w_new;
                            win_we     = 1'b1;
                            win_addr   = next_round[3:0];
                            win_wdata  = w_new;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            out_word_q  <= 32'd0;
            out_round_q <= 6'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_word_q  <= out_word_d;
            out_round_q <= out_round_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // The window holds data only. Every slot is written during LOAD before
    // it is read, so it has no reset and can map onto plain storage.
    always_ff @(posedge clk) begin
        if (win_we) begin
            win_q[win_addr] <= win_wdata;
        end
    end

endmodule
